// File: rtl/uart_pkg.sv
// Shared constants for the UART frame sequencer: state encoding, default widths
// and the saturating frame-counter helper.
package uart_pkg;

  localparam int DEFAULT_FRAME_W = 320;
  localparam int FRAMES_SENT_W   = 16;
  localparam int STATE_W         = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD   = 3'd1;
  localparam logic [STATE_W-1:0] ST_SEND   = 3'd2;
  localparam logic [STATE_W-1:0] ST_GAP    = 3'd3;
  localparam logic [STATE_W-1:0] ST_FINISH = 3'd4;

  // Holds at all-ones instead of wrapping back to zero.
  function automatic logic [FRAMES_SENT_W-1:0] sat_inc(input logic [FRAMES_SENT_W-1:0] v);
    return (&v) ? v : v + FRAMES_SENT_W'(1);
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Loadable down-counter that times the idle gap between consecutive frames.
module uart_gap_timer #(
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [GAP_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o,
  output logic             expire_o
);

  logic [GAP_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - GAP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // expire marks the last gap cycle, so the FSM can leave GAP on the same edge.
  assign zero_o   = (count_q == '0);
  assign expire_o = (count_q == GAP_W'(1));

endmodule

// File: rtl/uart_frame_sequencer.sv
// Steps through NUM_FRAMES frames from the caller's source, presenting each on
// the send/send_done handshake with a programmable idle gap in between.
module uart_frame_sequencer
  import uart_pkg::*;
#(
  parameter int FRAME_W    = DEFAULT_FRAME_W,
  parameter int NUM_FRAMES = 4,
  parameter int IDX_W      = 2,
  parameter int GAP_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     repeat_en,
  input  logic [GAP_W-1:0]         gap_cycles,
  output logic [IDX_W-1:0]         frame_idx,
  input  logic [FRAME_W-1:0]       frame_in,
  output logic                     send,
  output logic [FRAME_W-1:0]       data,
  input  logic                     send_done,
  output logic                     busy,
  output logic                     seq_done,
  output logic [FRAMES_SENT_W-1:0] frames_sent,
  output logic [STATE_W-1:0]       sta
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FRAMES - 1);

  logic [STATE_W-1:0]       state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [FRAME_W-1:0]       data_q, data_d;
  logic [FRAMES_SENT_W-1:0] sent_q, sent_d;
  logic                     send_q, send_d;
  logic                     busy_q, busy_d;
  logic                     seq_done_q, seq_done_d;

  logic gap_load, gap_dec, gap_zero, gap_expire;

  uart_gap_timer #(
    .GAP_W (GAP_W)
  ) u_gap_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (gap_load),
    .load_val_i (gap_cycles),
    .dec_i      (gap_dec),
    .zero_o     (gap_zero),
    .expire_o   (gap_expire)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    sent_d     = sent_q;
    seq_done_d = 1'b0;
    gap_load   = 1'b0;
    gap_dec    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end

      ST_LOAD: begin
        data_d   = frame_in;
        gap_load = 1'b1;
        state_d  = ST_SEND;
      end

      // The last frame always goes through FINISH; a zero gap skips GAP entirely.
      ST_SEND: begin
        if (send_done) begin
          sent_d = sat_inc(sent_q);
          if (idx_q == LAST_IDX) begin
            state_d = ST_FINISH;
          end else if (gap_zero) begin
            state_d = ST_LOAD;
            idx_d   = idx_q + IDX_W'(1);
          end else begin
            state_d = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        gap_dec = 1'b1;
        if (gap_expire) begin
          state_d = ST_LOAD;
          idx_d   = idx_q + IDX_W'(1);
        end
      end

      ST_FINISH: begin
        idx_d = '0;
        if (repeat_en) begin
          state_d = ST_LOAD;
        end else begin
          seq_done_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // send is only ever high in SEND, so it follows the next state directly.
  assign send_d = (state_d == ST_SEND);
  assign busy_d = (state_d != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      data_q     <= '0;
      sent_q     <= '0;
      send_q     <= 1'b0;
      busy_q     <= 1'b0;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      sent_q     <= sent_d;
      send_q     <= send_d;
      busy_q     <= busy_d;
      seq_done_q <= seq_done_d;
    end
  end

  assign frame_idx   = idx_q;
  assign data        = data_q;
  assign frames_sent = sent_q;
  assign send        = send_q;
  assign busy        = busy_q;
  assign seq_done    = seq_done_q;
  assign sta         = state_q;

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Randomized bench for uart_frame_sequencer: a timeline model of the sequence
// rules is compared every cycle, plus directed checks with hand-derived values.
`timescale 1ns/1ps
module tb_uart_frame_sequencer;
  import uart_pkg::*;

  localparam int FRAME_W    = 320;
  localparam int NUM_FRAMES = 4;
  localparam int IDX_W      = 2;
  localparam int GAP_W      = 8;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     start = 1'b0;
  logic                     repeat_en;
  logic [GAP_W-1:0]         gap_cycles = '0;
  logic [IDX_W-1:0]         frame_idx;
  logic [FRAME_W-1:0]       frame_in;
  logic                     send;
  logic [FRAME_W-1:0]       data;
  logic                     send_done;
  logic                     busy;
  logic                     seq_done;
  logic [FRAMES_SENT_W-1:0] frames_sent;
  logic [STATE_W-1:0]       sta;

  logic [FRAME_W-1:0] frameTab [2**IDX_W];

  int checks = 0;
  int failures = 0;
  bit checksOn = 1'b0;

  // Responder / stimulus configuration
  bit autoDone = 1'b0, holdDone = 1'b0, randDelay = 1'b0, randRepeat = 1'b0, repeatLevel = 1'b0;
  int fixedDelay = 5;
  int strayCnt = 0;

  // Model state
  bit mSend, mSeqDone;
  logic [FRAME_W-1:0] mData;
  int mIdx, mSent, mSta;

  // Directed-check counters
  int clearReq = 0;
  int riseCount, gapCount, sendCycleCount, doneCount, lowRun, maxLow;
  int riseIdx [64];
  logic [FRAME_W-1:0] riseData [64];

  assign frame_in = frameTab[frame_idx];

  uart_frame_sequencer #(
    .FRAME_W    (FRAME_W),
    .NUM_FRAMES (NUM_FRAMES),
    .IDX_W      (IDX_W),
    .GAP_W      (GAP_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .repeat_en   (repeat_en),
    .gap_cycles  (gap_cycles),
    .frame_idx   (frame_idx),
    .frame_in    (frame_in),
    .send        (send),
    .data        (data),
    .send_done   (send_done),
    .busy        (busy),
    .seq_done    (seq_done),
    .frames_sent (frames_sent),
    .sta         (sta)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [FRAME_W-1:0] actual,
                             input logic [FRAME_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // ---------------- behavioural model ----------------
  task automatic edgeWait(output bit r);
    @(posedge clk);
    r = rst;
  endtask

  task automatic resetModel();
    mSend = 1'b0; mData = '0; mIdx = 0; mSent = 0; mSta = 0; mSeqDone = 1'b0;
  endtask

  // Called on the edge where start was accepted; walks one whole sequence.
  task automatic runSequence();
    bit r;
    int gap;
    mSta = 1; mIdx = 0;
    forever begin
      edgeWait(r); if (r) begin resetModel(); return; end
      mData = frameTab[mIdx]; gap = int'(gap_cycles); mSta = 2; mSend = 1'b1;
      forever begin
        edgeWait(r); if (r) begin resetModel(); return; end
        if (send_done) break;
      end
      mSend = 1'b0;
      if (mSent < 65535) mSent++;
      if (mIdx == NUM_FRAMES - 1) begin
        mSta = 4;
        edgeWait(r); if (r) begin resetModel(); return; end
        mIdx = 0;
        if (repeat_en) begin
          mSta = 1;
          continue;
        end
        mSeqDone = 1'b1; mSta = 0;
        return;
      end
      if (gap != 0) begin
        mSta = 3;
        repeat (gap) begin
          edgeWait(r); if (r) begin resetModel(); return; end
        end
      end
      mIdx++; mSta = 1;
    end
  endtask

  initial begin : modelProc
    bit r;
    resetModel();
    forever begin
      edgeWait(r);
      mSeqDone = 1'b0;
      if (r) resetModel();
      else if (start) runSequence();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compareProc
    forever begin
      @(negedge clk);
      if (checksOn) begin
        checkOutput("send", FRAME_W'(send), FRAME_W'(mSend));
        checkOutput("data", data, mData);
        checkOutput("frame_idx", FRAME_W'(frame_idx), FRAME_W'(mIdx));
        checkOutput("busy", FRAME_W'(busy), FRAME_W'(mSta != 0));
        checkOutput("seq_done", FRAME_W'(seq_done), FRAME_W'(mSeqDone));
        checkOutput("frames_sent", FRAME_W'(frames_sent), FRAME_W'(mSent));
        checkOutput("sta", FRAME_W'(sta), FRAME_W'(mSta));
      end
    end
  end

  // ---------------- send_done responder ----------------
  initial begin : responderProc
    int sendAge = 0;
    int curDelay = 1;
    int strayServed = 0;
    send_done = 1'b0;
    repeat_en = 1'b0;
    forever begin
      @(negedge clk);
      if (holdDone) begin
        send_done = 1'b1;
      end else begin
        send_done = 1'b0;
        if (send) begin
          sendAge++;
          if (autoDone && sendAge == curDelay) send_done = 1'b1;
        end else begin
          sendAge = 0;
          curDelay = randDelay ? int'($urandom_range(1, 6)) : fixedDelay;
        end
      end
      if (strayCnt != strayServed) begin
        send_done = 1'b1;
        strayServed++;
      end
      repeat_en = randRepeat ? ($urandom_range(0, 2) == 0) : repeatLevel;
    end
  end

  // ---------------- directed-check monitor ----------------
  initial begin : monitorProc
    int clearSeen = 0;
    bit prevSend = 1'b0;
    forever begin
      @(negedge clk);
      if (clearSeen != clearReq) begin
        clearSeen = clearReq;
        riseCount = 0; gapCount = 0; sendCycleCount = 0; doneCount = 0; lowRun = 0; maxLow = 0;
      end
      if (send && !prevSend) begin
        if (riseCount < 64) begin
          riseIdx[riseCount] = int'(frame_idx);
          riseData[riseCount] = data;
        end
        riseCount++;
      end
      prevSend = send;
      if (seq_done) doneCount++;
      if (sta == ST_GAP) gapCount++;
      if (sta == ST_SEND) sendCycleCount++;
      if (busy && !send) begin
        lowRun++;
      end else begin
        if (send && lowRun > maxLow) maxLow = lowRun;
        lowRun = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clearCounters();
    clearReq++;
    @(negedge clk);
  endtask

  task automatic setFrames(input bit randomContent);
    for (int i = 0; i < 2**IDX_W; i++) begin
      if (randomContent) begin
        for (int w = 0; w < FRAME_W / 32; w++) frameTab[i][w*32 +: 32] = $urandom;
      end else begin
        frameTab[i] = FRAME_W'(i * 'h11);
      end
    end
  endtask

  task automatic applyStimulus(input int gap, input bit randomContent);
    setFrames(randomContent);
    @(negedge clk);
    gap_cycles = GAP_W'(gap);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int maxCycles);
    int n = 0;
    @(negedge clk);
    while (busy && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, FRAME_W'(busy), '0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checksOn = 1'b1;
  endtask

  initial begin : watchdog
    #1000000;
    failures++;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin : mainProc
    int n;
    setFrames(1'b0);
    doReset();
    checkOutput("reset_sta", FRAME_W'(sta), '0);
    checkOutput("reset_data", data, '0);

    // Reset while a frame is being sent
    autoDone = 1'b0;
    applyStimulus(2, 1'b0);
    n = 0;
    while (!send && n < 10) begin @(negedge clk); n++; end
    checkOutput("t1_send_up", FRAME_W'(send), FRAME_W'(1));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t1_send", FRAME_W'(send), '0);
    checkOutput("t1_sta", FRAME_W'(sta), '0);
    checkOutput("t1_busy", FRAME_W'(busy), '0);
    checkOutput("t1_frames", FRAME_W'(frames_sent), '0);
    strayCnt++;
    repeat (3) @(negedge clk);
    strayCnt++;
    repeat (3) @(negedge clk);
    checkOutput("t1_stray_frames", FRAME_W'(frames_sent), '0);
    checkOutput("t1_stray_sta", FRAME_W'(sta), '0);

    // Single shot, gap 3, done 5 cycles after each send rise
    autoDone = 1'b1; fixedDelay = 5; randDelay = 1'b0; repeatLevel = 1'b0;
    clearCounters();
    applyStimulus(3, 1'b0);
    waitIdle("t2_idle", 300);
    checkOutput("t2_rises", FRAME_W'(riseCount), FRAME_W'(4));
    for (int i = 0; i < 4; i++) checkOutput($sformatf("t2_data%0d", i), riseData[i], FRAME_W'(i * 'h11));
    checkOutput("t2_gap_cycles", FRAME_W'(gapCount), FRAME_W'(9));
    checkOutput("t2_seq_done", FRAME_W'(doneCount), FRAME_W'(1));
    checkOutput("t2_frames", FRAME_W'(frames_sent), FRAME_W'(4));

    // Zero gap: send low exactly one cycle between frames
    randDelay = 1'b1;
    clearCounters();
    applyStimulus(0, 1'b1);
    waitIdle("t3_idle", 300);
    checkOutput("t3_gap_cycles", FRAME_W'(gapCount), '0);
    checkOutput("t3_max_low", FRAME_W'(maxLow), FRAME_W'(1));
    checkOutput("t3_rises", FRAME_W'(riseCount), FRAME_W'(4));
    checkOutput("t3_frames", FRAME_W'(frames_sent), FRAME_W'(8));

    // Repeat for two passes, then single shot
    repeatLevel = 1'b1;
    clearCounters();
    applyStimulus(2, 1'b1);
    n = 0;
    while (riseCount < 6 && n < 500) begin @(negedge clk); n++; end
    checkOutput("t4_reach_pass2", FRAME_W'(riseCount >= 6), FRAME_W'(1));
    repeatLevel = 1'b0;
    waitIdle("t4_idle", 500);
    checkOutput("t4_rises", FRAME_W'(riseCount), FRAME_W'(8));
    for (int i = 0; i < 8; i++) checkOutput($sformatf("t4_idx%0d", i), FRAME_W'(riseIdx[i]), FRAME_W'(i % 4));
    checkOutput("t4_gap_cycles", FRAME_W'(gapCount), FRAME_W'(12));
    checkOutput("t4_seq_done", FRAME_W'(doneCount), FRAME_W'(1));
    checkOutput("t4_frames", FRAME_W'(frames_sent), FRAME_W'(16));

    // send_done held high the whole time
    holdDone = 1'b1;
    clearCounters();
    applyStimulus(0, 1'b1);
    waitIdle("t5_idle", 100);
    holdDone = 1'b0;
    checkOutput("t5_send_cycles", FRAME_W'(sendCycleCount), FRAME_W'(4));
    checkOutput("t5_rises", FRAME_W'(riseCount), FRAME_W'(4));
    checkOutput("t5_frames", FRAME_W'(frames_sent), FRAME_W'(20));
    checkOutput("t5_seq_done", FRAME_W'(doneCount), FRAME_W'(1));

    // Stray send_done in IDLE and GAP, start pulsed mid-sequence
    randDelay = 1'b0; fixedDelay = 3;
    clearCounters();
    strayCnt++;
    repeat (3) @(negedge clk);
    checkOutput("t6_idle_frames", FRAME_W'(frames_sent), FRAME_W'(20));
    applyStimulus(4, 1'b1);
    n = 0;
    while (sta != ST_GAP && n < 50) begin @(negedge clk); n++; end
    checkOutput("t6_reach_gap", FRAME_W'(sta), FRAME_W'(ST_GAP));
    strayCnt++;
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    waitIdle("t6_idle", 300);
    checkOutput("t6_rises", FRAME_W'(riseCount), FRAME_W'(4));
    checkOutput("t6_frames", FRAME_W'(frames_sent), FRAME_W'(24));
    checkOutput("t6_gap_cycles", FRAME_W'(gapCount), FRAME_W'(12));
    checkOutput("t6_seq_done", FRAME_W'(doneCount), FRAME_W'(1));

    // Randomized sequences; the per-cycle model does the checking
    randDelay = 1'b1; randRepeat = 1'b1;
    for (int it = 0; it < 6; it++) begin
      setFrames(1'b1);
      @(negedge clk);
      gap_cycles = GAP_W'($urandom_range(0, 4));
      start = 1'b1;
      n = int'($urandom_range(1, 40));
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 15) == 0) strayCnt++;
        if (it == 3 && c == n / 2) rst = 1'b1;
        else rst = 1'b0;
      end
      rst = 1'b0;
      start = 1'b0;
      waitIdle($sformatf("rand%0d_idle", it), 3000);
    end
    randRepeat = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_frame_sequencer.md
Name: uart_frame_sequencer

Overview:
Parametrised frame sequencer feeding the UART transmitter. It pulls NUM_FRAMES frames of FRAME_W bits from a caller-side frame source by index and presents each on a send/send_done handshake. Consecutive frames are separated by a programmable idle gap. Supports single-shot and continuous repeat; it replaces the fixed single-frame test driver in front of the UART sender.

Parameters:
FRAME_W, 320, width of one frame presented to the UART sender
NUM_FRAMES, 4, frames per sequence (>=1)
IDX_W, 2, width of frame index; must satisfy 2**IDX_W >= NUM_FRAMES
GAP_W, 8, width of the gap counter

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous to clk, active-high
start  in  1  level; sampled in IDLE, starts a sequence
repeat_en  in  1  1 = restart at frame 0 after the last frame; sampled at every sequence end
gap_cycles  in  GAP_W  idle cycles between frames; sampled at LOAD
frame_idx  out  IDX_W  index of the frame currently requested from the source
frame_in  in  FRAME_W  frame contents for frame_idx; combinational from the caller
send  out  1  request to the UART sender
data  out  FRAME_W  registered frame presented to the UART sender
send_done  in  1  one-cycle pulse from the UART sender: frame fully transmitted
busy  out  1  high in every state except IDLE
seq_done  out  1  one-cycle pulse when a single-shot sequence completes
frames_sent  out  16  saturating count of completed frames since reset
sta  out  3  current state encoding, for debug LEDs

Behaviour:
- Reset (rst=1 at a clk edge) forces state IDLE. All outputs are 0: send, data, frame_idx, busy, seq_done, frames_sent, sta. Reset mid-transfer drops send on the next edge; the UART sender is not waited on.
- States and encoding: IDLE=0, LOAD=1, SEND=2, GAP=3, FINISH=4. All outputs are registered.
- IDLE: on start=1 -> LOAD with frame_idx=0.
- LOAD: one cycle.
  - data <= frame_in.
  - Gap counter <= gap_cycles.
  - Next state SEND. send rises on the same edge, so data and send go valid together.
- SEND:
  - send is held at 1 and data is held stable.
  - On send_done=1: send <= 0 and frames_sent <= frames_sent+1 (saturates at 0xFFFF).
  - If send_done=1 and this is the last frame (frame_idx == NUM_FRAMES-1) -> FINISH.
  - If send_done=1 and not the last frame -> GAP, or directly to LOAD with frame_idx+1 when the gap counter is 0.
  - send_done while not in SEND is ignored.
- GAP: the counter decrements each cycle. When it is 1 -> LOAD with frame_idx+1.
  - gap_cycles=N yields exactly N cycles in GAP.
  - N=0 skips GAP entirely.
- FINISH: one cycle.
  - repeat_en=1 -> LOAD with frame_idx=0; the gap is not applied.
  - repeat_en=0 -> seq_done pulses 1 for this cycle, frame_idx <= 0, next state IDLE.
- start held high in IDLE after a sequence restarts it immediately. start outside IDLE is ignored.
- Latency:
  - start sampled to send=1: 2 edges (IDLE->LOAD, LOAD->SEND).
  - send_done to send low: 1 edge.
  - send_done to next send=1 with gap 0: 2 edges.
- frame_idx wrap: never exceeds NUM_FRAMES-1, even when 2**IDX_W > NUM_FRAMES.
- busy = (state != IDLE). sta mirrors the state encoding.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding constants (ST_IDLE..ST_FINISH)
  - the default FRAME_W
  - the frames_sent width constant (16)
- One natural sub-module: uart_gap_timer, a loadable down-counter of GAP_W bits with a load/expire interface. Everything else stays in the top FSM.

Test Plan:
1. Reset mid-SEND: assert rst while send=1 -> next edge send=0, sta=0, frames_sent=0, busy=0; later send_done pulses have no effect.
2. Single-shot, NUM_FRAMES=4, gap_cycles=3, send_done 5 cycles after each send rise, frame_in=idx*0x11 -> four sends with data 0x00,0x11,0x22,0x33; exactly 3 GAP cycles between frames; one seq_done pulse; frames_sent=4; returns to IDLE.
3. gap_cycles=0 -> send low for exactly 1 cycle between frames; GAP state never visible on sta.
4. repeat_en=1 for 2 passes, then deasserted -> frame_idx sequence 0,1,2,3,0,1,2,3; no gap between frames 3 and 0; seq_done pulses once, only after the pass ending with repeat_en=0.
5. send_done held at 1 continuously -> each frame occupies exactly 1 SEND cycle; no frame skipped; frames_sent increments once per frame.
6. Stray send_done in IDLE or GAP, and start pulsed mid-sequence -> no state change, no extra frames, frames_sent unchanged.
